xadac_elastic_buf: RTL and testbench
====================================

Name: xadac_elastic_buf

Overview:
Parametrised elastic buffer for valid/ready streams in the xadac datapath; the multi-entry successor to the single-entry skid stage. Stores up to Depth beats in a circular buffer, with an optional fall-through mode, synchronous flush and occupancy reporting. Placed between xadac pipeline stages and at the coprocessor request/response boundaries to cut ready timing paths and absorb backpressure bursts.

Parameters:
Depth, 2, number of storage entries; legal range 1..64, any value (non-power-of-two allowed)
Bypass, 0, 1 = when empty, slv side falls through combinationally to mst side (zero latency); 0 = always registered (latency 1)
DataT, logic, payload type
CntW, $clog2(Depth+1), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous discard of all stored beats
slv_data  in  DataT  upstream payload
slv_valid  in  1  upstream valid
slv_ready  out  1  upstream ready
mst_data  out  DataT  downstream payload
mst_valid  out  1  downstream valid
mst_ready  in  1  downstream ready
count  out  CntW  number of stored beats, 0..Depth
full  out  1  count == Depth
empty  out  1  count == 0

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high: rd_ptr, wr_ptr, count = 0; storage = '0; slv_ready = 0; mst_valid = 0; mst_data = '0; full = 0; empty = 1. slv_ready rises in the first cycle after rst deasserts. Reset mid-transfer drops all stored beats with no output.
- Transfers: push = slv_valid && slv_ready; pop = mst_valid && mst_ready. Upstream must hold slv_data/slv_valid stable until accepted; this block holds mst_data/mst_valid stable until accepted.
- slv_ready = !full && !flush && !rst. It depends only on registered state and flush, never on mst_ready (no ready combinational path), so a full buffer refuses push even when pop occurs that cycle.
- Bypass=0: mst_valid = !empty && !flush; mst_data = storage[rd_ptr]. A push into the empty buffer is first visible on mst at the next cycle (latency 1). Throughput is 1 beat/cycle when Depth >= 2; with Depth=1, at most 1 beat per 2 cycles.
- Bypass=1: when empty and not flush, mst_valid = slv_valid and mst_data = slv_data; if mst_ready is also high, the beat passes through without being written and count stays 0. If mst_ready is low, the beat is written and count becomes 1. When not empty, behaviour matches Bypass=0 (FIFO order is preserved; no bypass around stored beats).
- Pointers advance by 1 on write and on read respectively, and wrap from Depth-1 to 0. count next = count + push_stored - pop_stored; simultaneous push and pop when 0 < count < Depth leaves count unchanged.
- flush (synchronous, highest priority after rst): in the flush cycle, slv_ready = 0 and mst_valid = 0 (no transfer can complete); on the next edge, pointers and count = 0. Storage contents need not be cleared.
- full/empty/count are registered-derived and glitch-free; never count > Depth (assertion); push when full or pop when empty is impossible by construction (assertions in the bench).

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then 0 -> during reset slv_ready=0, mst_valid=0, count=0, empty=1; slv_ready=1 in the first cycle after release.
- Fill/drain, Depth=4, Bypass=0: push 0xA0..0xA5 with mst_ready=0 -> 4 accepted, slv_ready=0 and full=1 at count=4; then mst_ready=1 -> out 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then 0xA4,0xA5 follow; count returns to 0.
- Wrap, Depth=3: stream 10 beats (0..9) with random mst_ready (seeded) -> output order 0..9 exact, no loss or duplication, count <= 3 every cycle.
- Bypass=1, empty, slv_valid=1, mst_ready=1, data 0x55 -> mst_valid=1 and mst_data=0x55 in the same cycle; count stays 0. Repeat with mst_ready=0 -> count=1, and 0x55 is presented on the next cycle.
- Flush with count=2 (0x11,0x22 stored) and slv_valid=1 -> flush cycle: slv_ready=0, mst_valid=0; next cycle: count=0, empty=1; a new push of 0x33 is the first beat output.
- Async reset mid-stream: assert rst between clock edges with count=3 -> outputs take reset values immediately without a clock edge; after release, nothing from the old stream appears at mst.

Source files
------------

// File: rtl/xadac_elastic_buf.sv
// -----------------------------------------------------------------------------
// xadac_elastic_buf
//
// Multi-entry elastic buffer for valid/ready streams. Beats are held in a
// circular buffer of Depth entries. slv_ready depends only on registered
// occupancy and flush, never on mst_ready, so the downstream ready path stops
// here. With Bypass=1 an empty buffer passes the upstream beat straight through
// in the same cycle. With Bypass=0 every beat is registered first.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous discard of all stored beats
//   slv_data   upstream payload
//   slv_valid  upstream valid
//   slv_ready  upstream ready (registered-state only)
//   mst_data   downstream payload
//   mst_valid  downstream valid
//   mst_ready  downstream ready
//   count      number of stored beats, 0..Depth
//   full       count == Depth
//   empty      count == 0
// -----------------------------------------------------------------------------
module xadac_elastic_buf #(
    parameter int   Depth  = 2,
    parameter bit   Bypass = 1'b0,
    parameter type  DataT  = logic,
    // Derived from Depth; leave at its default.
    parameter int   CntW   = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  DataT            slv_data,
    input  logic            slv_valid,
    output logic            slv_ready,
    output DataT            mst_data,
    output logic            mst_valid,
    input  logic            mst_ready,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    DataT            storage_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic pass_through;
    logic wr_en;
    logic rd_en;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        slv_ready = !full && !flush && !rst;

        // Bypass only applies while nothing is stored, so FIFO order holds.
        if (Bypass && empty) begin
            mst_valid = slv_valid && !flush && !rst;
            mst_data  = rst ? DataT'('0) : slv_data;
        end else begin
            mst_valid = !empty && !flush && !rst;
            mst_data  = rst ? DataT'('0) : storage_q[rd_ptr_q];
        end

        push = slv_valid && slv_ready;
        pop  = mst_valid && mst_ready;

        // A beat consumed in the same cycle it arrives at an empty bypass
        // buffer never touches storage.
        pass_through = Bypass && empty && push && mst_ready;
        wr_en        = push && !pass_through;
        rd_en        = pop && !pass_through;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // One enable-gated register per entry; only the slot under wr_ptr loads.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                storage_q[gi] <= '0;
            end else if (wr_en && (wr_ptr_q == PtrW'(gi))) begin
                storage_q[gi] <= slv_data;
            end
        end
    end

endmodule

// File: tb/tb_xadac_elastic_buf.sv
// -----------------------------------------------------------------------------
// Directed bench for xadac_elastic_buf. Three instances share clk/rst/flush:
//   u4 : Depth=4, Bypass=0  (fill/drain, flush, async reset)
//   u3 : Depth=3, Bypass=0  (pointer wrap with irregular mst_ready)
//   ub : Depth=2, Bypass=1  (fall-through)
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_xadac_elastic_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] s4_data, m4_data;
    logic       s4_valid, s4_ready, m4_valid, m4_ready, f4_full, f4_empty;
    logic [2:0] c4_count;

    logic [7:0] s3_data, m3_data;
    logic       s3_valid, s3_ready, m3_valid, m3_ready, f3_full, f3_empty;
    logic [1:0] c3_count;

    logic [7:0] sb_data, mb_data;
    logic       sb_valid, sb_ready, mb_valid, mb_ready, fb_full, fb_empty;
    logic [1:0] cb_count;

    xadac_elastic_buf #(.Depth(4), .Bypass(1'b0), .DataT(logic [7:0])) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .slv_data(s4_data), .slv_valid(s4_valid), .slv_ready(s4_ready),
        .mst_data(m4_data), .mst_valid(m4_valid), .mst_ready(m4_ready),
        .count(c4_count), .full(f4_full), .empty(f4_empty)
    );

    xadac_elastic_buf #(.Depth(3), .Bypass(1'b0), .DataT(logic [7:0])) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .slv_data(s3_data), .slv_valid(s3_valid), .slv_ready(s3_ready),
        .mst_data(m3_data), .mst_valid(m3_valid), .mst_ready(m3_ready),
        .count(c3_count), .full(f3_full), .empty(f3_empty)
    );

    xadac_elastic_buf #(.Depth(2), .Bypass(1'b1), .DataT(logic [7:0])) ub (
        .clk(clk), .rst(rst), .flush(flush),
        .slv_data(sb_data), .slv_valid(sb_valid), .slv_ready(sb_ready),
        .mst_data(mb_data), .mst_valid(mb_valid), .mst_ready(mb_ready),
        .count(cb_count), .full(fb_full), .empty(fb_empty)
    );

    // Structural invariants.
    a_cnt4: assert property (@(posedge clk) disable iff (rst) c4_count <= 3'd4)
        else $error("u4 count above depth");
    a_cnt3: assert property (@(posedge clk) disable iff (rst) c3_count <= 2'd3)
        else $error("u3 count above depth");
    a_cntb: assert property (@(posedge clk) disable iff (rst) cb_count <= 2'd2)
        else $error("ub count above depth");
    a_pf4: assert property (@(posedge clk) disable iff (rst) !(s4_valid && s4_ready && f4_full))
        else $error("u4 push while full");
    a_pf3: assert property (@(posedge clk) disable iff (rst) !(s3_valid && s3_ready && f3_full))
        else $error("u3 push while full");
    a_pe4: assert property (@(posedge clk) disable iff (rst) !(m4_valid && f4_empty))
        else $error("u4 pop while empty");
    a_pe3: assert property (@(posedge clk) disable iff (rst) !(m3_valid && f3_empty))
        else $error("u3 pop while empty");
    a_peb: assert property (@(posedge clk) disable iff (rst)
                            !(mb_valid && mb_ready && fb_empty && !(sb_valid && sb_ready)))
        else $error("ub pop while empty without pass-through");

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int idx, out_idx, cyc;
    logic push_now;
    logic [7:0] lfsr;

    initial begin
        s4_data = '0; s4_valid = 0; m4_ready = 0;
        s3_data = '0; s3_valid = 0; m3_ready = 0;
        sb_data = '0; sb_valid = 0; mb_ready = 0;

        // ---------------- reset / idle ----------------
        repeat (3) tick();
        #1;
        check("rst_slv_ready4", 32'(s4_ready), 0);
        check("rst_mst_valid4", 32'(m4_valid), 0);
        check("rst_count4",     32'(c4_count), 0);
        check("rst_empty4",     32'(f4_empty), 1);
        check("rst_full4",      32'(f4_full),  0);
        check("rst_mst_data4",  32'(m4_data),  0);
        check("rst_slv_readyb", 32'(sb_ready), 0);
        rst = 0;
        #1;
        check("rel_slv_ready4", 32'(s4_ready), 1);
        check("rel_slv_ready3", 32'(s3_ready), 1);
        check("rel_slv_readyb", 32'(sb_ready), 1);
        tick();

        // ---------------- fill / drain, Depth=4 ----------------
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            s4_valid = 1;
            s4_data  = 8'hA0 + 8'(idx);
            #1;
            push_now = s4_ready;
            tick();
            if (push_now) idx++;
        end
        #1;
        check("fill_accepted", 32'(idx), 4);
        check("fill_count",    32'(c4_count), 4);
        check("fill_full",     32'(f4_full), 1);
        check("fill_slv_ready", 32'(s4_ready), 0);
        check("fill_head",     32'(m4_data), 32'h A0);

        m4_ready = 1;
        out_idx  = 0;
        cyc      = 0;
        while (out_idx < 6 && cyc < 20) begin
            s4_valid = (idx < 6);
            s4_data  = 8'hA0 + 8'(idx);
            #1;
            if (cyc == 0) check("full_no_ready_path", 32'(s4_ready), 0);
            push_now = s4_valid && s4_ready;
            if (m4_valid) begin
                check($sformatf("drain_%0d", out_idx), 32'(m4_data), 32'(8'hA0 + 8'(out_idx)));
                out_idx++;
            end
            tick();
            if (push_now) idx++;
            cyc++;
        end
        check("drain_beats",  32'(out_idx), 6);
        check("drain_cycles", 32'(cyc), 6);
        check("drain_count",  32'(c4_count), 0);
        check("drain_empty",  32'(f4_empty), 1);
        s4_valid = 0;
        m4_ready = 0;

        // ---------------- wrap, Depth=3 ----------------
        lfsr    = 8'hA5;
        idx     = 0;
        out_idx = 0;
        cyc     = 0;
        while (out_idx < 10 && cyc < 100) begin
            s3_valid = (idx < 10);
            s3_data  = 8'(idx);
            m3_ready = lfsr[0];
            lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            #1;
            push_now = s3_valid && s3_ready;
            if (m3_valid && m3_ready) begin
                check($sformatf("wrap_%0d", out_idx), 32'(m3_data), 32'(out_idx));
                out_idx++;
            end
            tick();
            if (push_now) idx++;
            cyc++;
        end
        check("wrap_beats", 32'(out_idx), 10);
        check("wrap_count", 32'(c3_count), 0);
        s3_valid = 0;
        m3_ready = 0;

        // ---------------- bypass, Depth=2 ----------------
        sb_valid = 1;
        sb_data  = 8'h55;
        mb_ready = 1;
        #1;
        check("byp_valid", 32'(mb_valid), 1);
        check("byp_data",  32'(mb_data), 32'h55);
        tick();
        check("byp_count0", 32'(cb_count), 0);
        mb_ready = 0;
        #1;
        check("byp_stall_valid", 32'(mb_valid), 1);
        tick();
        sb_valid = 0;
        sb_data  = 8'h00;
        #1;
        check("byp_stall_count", 32'(cb_count), 1);
        check("byp_held_valid",  32'(mb_valid), 1);
        check("byp_held_data",   32'(mb_data), 32'h55);
        mb_ready = 1;
        tick();
        check("byp_after_count", 32'(cb_count), 0);
        mb_ready = 0;

        // ---------------- flush, Depth=4 ----------------
        s4_valid = 1; s4_data = 8'h11; tick();
        s4_data = 8'h22; tick();
        check("fl_pre_count", 32'(c4_count), 2);
        s4_data = 8'h99;
        flush   = 1;
        #1;
        check("fl_slv_ready", 32'(s4_ready), 0);
        check("fl_mst_valid", 32'(m4_valid), 0);
        tick();
        flush = 0;
        check("fl_count", 32'(c4_count), 0);
        check("fl_empty", 32'(f4_empty), 1);
        s4_data = 8'h33;
        tick();
        s4_valid = 0;
        #1;
        check("fl_new_valid", 32'(m4_valid), 1);
        check("fl_new_data",  32'(m4_data), 32'h33);
        m4_ready = 1;
        tick();
        m4_ready = 0;
        check("fl_new_count", 32'(c4_count), 0);

        // ---------------- async reset mid-stream ----------------
        s4_valid = 1;
        for (int i = 0; i < 3; i++) begin
            s4_data = 8'hB0 + 8'(i);
            tick();
        end
        s4_valid = 0;
        #1;
        check("ar_pre_count", 32'(c4_count), 3);
        #2;
        rst = 1;
        #1;
        check("ar_count",     32'(c4_count), 0);
        check("ar_empty",     32'(f4_empty), 1);
        check("ar_mst_valid", 32'(m4_valid), 0);
        check("ar_slv_ready", 32'(s4_ready), 0);
        check("ar_mst_data",  32'(m4_data), 0);
        tick();
        rst      = 0;
        m4_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("ar_quiet_%0d", i), 32'(m4_valid), 0);
            tick();
        end
        m4_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
